// File: rtl/memarb_if.sv
// Shared-port bus between the two cache requesters, the arbiter and ramctrl.
// slave is the arbiter's view; master is the surrounding caches plus ramctrl.
interface memarb_if #(
    parameter int unsigned AW = 27,
    parameter int unsigned DW = 32
);
    logic          inst_stb;
    logic [AW-1:0] inst_addr;
    logic [DW-1:0] inst_dout;
    logic          inst_ack;
    logic          inst_timeout;

    logic          data_stb;
    logic          data_we;
    logic [AW-1:0] data_addr;
    logic [DW-1:0] data_din;
    logic [DW-1:0] data_dout;
    logic          data_ack;
    logic          data_timeout;

    logic          mem_stb;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_dout;
    logic [DW-1:0] mem_din;
    logic          mem_ack;
    logic          mem_timeout;

    modport slave (
        input  inst_stb, inst_addr,
        output inst_dout, inst_ack, inst_timeout,
        input  data_stb, data_we, data_addr, data_din,
        output data_dout, data_ack, data_timeout,
        output mem_stb, mem_we, mem_addr, mem_dout,
        input  mem_din, mem_ack, mem_timeout
    );

    modport master (
        output inst_stb, inst_addr,
        input  inst_dout, inst_ack, inst_timeout,
        output data_stb, data_we, data_addr, data_din,
        input  data_dout, data_ack, data_timeout,
        input  mem_stb, mem_we, mem_addr, mem_dout,
        output mem_din, mem_ack, mem_timeout
    );
endinterface

// File: rtl/memarb.sv
// Round-robin arbiter sharing the ramctrl port between instruction fetch and data.
// Grant is held until ramctrl acks or times out; read data is broadcast to both sides.
module memarb #(
    parameter int unsigned AW = 27,
    parameter int unsigned DW = 32
) (
    input  logic      clk,
    input  logic      rst,
    memarb_if.slave   bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } state_e;

    state_e state_q, state_d;
    logic   last_d_q, last_d_d;

    logic          stb_mux;
    logic          we_mux;
    logic [AW-1:0] addr_mux;
    logic [DW-1:0] dout_mux;
    logic          i_ack, i_to, d_ack, d_to;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            last_d_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            last_d_q <= last_d_d;
        end
    end

    // Requests are only sampled in IDLE; an owner leaving early also ends the grant.
    always_comb begin
        state_d  = state_q;
        last_d_d = last_d_q;
        unique case (state_q)
            IDLE: begin
                if (bus.inst_stb && (!bus.data_stb || last_d_q)) begin
                    state_d  = GNT_I;
                    last_d_d = 1'b0;
                end else if (bus.data_stb) begin
                    state_d  = GNT_D;
                    last_d_d = 1'b1;
                end
            end
            GNT_I: begin
                if (!bus.inst_stb || bus.mem_ack || bus.mem_timeout) begin
                    state_d = IDLE;
                end
            end
            GNT_D: begin
                if (!bus.data_stb || bus.mem_ack || bus.mem_timeout) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Mux select comes from the registered state only.
    always_comb begin
        stb_mux  = 1'b0;
        we_mux   = 1'b0;
        addr_mux = '0;
        dout_mux = '0;
        i_ack    = 1'b0;
        i_to     = 1'b0;
        d_ack    = 1'b0;
        d_to     = 1'b0;
        unique case (state_q)
            GNT_I: begin
                stb_mux  = bus.inst_stb;
                addr_mux = bus.inst_addr;
                i_ack    = bus.inst_stb & bus.mem_ack;
                i_to     = bus.inst_stb & bus.mem_timeout;
            end
            GNT_D: begin
                stb_mux  = bus.data_stb;
                we_mux   = bus.data_we;
                addr_mux = bus.data_addr;
                dout_mux = bus.data_din;
                d_ack    = bus.data_stb & bus.mem_ack;
                d_to     = bus.data_stb & bus.mem_timeout;
            end
            default: ;
        endcase
    end

    assign bus.mem_stb      = stb_mux;
    assign bus.mem_we       = we_mux;
    assign bus.mem_addr     = addr_mux;
    assign bus.mem_dout     = dout_mux;
    assign bus.inst_ack     = i_ack;
    assign bus.inst_timeout = i_to;
    assign bus.data_ack     = d_ack;
    assign bus.data_timeout = d_to;
    assign bus.inst_dout    = bus.mem_din;
    assign bus.data_dout    = bus.mem_din;

    a_single_owner: assert property (@(posedge clk) disable iff (!rst)
        !((i_ack || i_to) && (d_ack || d_to)));
    a_legal_state: assert property (@(posedge clk) disable iff (!rst)
        state_q inside {IDLE, GNT_I, GNT_D});
endmodule

// File: tb/tb_memarb.sv
// Scoreboard bench for memarb: stimulus pushes expected grants/completions,
// a negedge monitor pops and compares whenever the DUT starts or ends a transfer.
module tb_memarb;
    localparam int unsigned AW = 27;
    localparam int unsigned DW = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    memarb_if #(.AW(AW), .DW(DW)) bus();

    memarb #(.AW(AW), .DW(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] dout;
        int            cyc;
    } grant_t;

    typedef struct {
        logic [3:0]    flags;   // {inst_ack, inst_timeout, data_ack, data_timeout}
        logic [DW-1:0] rd;
        int            cyc;
    } done_t;

    grant_t grant_q[$];
    done_t  done_q[$];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void unexpected(input string name);
        checks++;
        errors++;
        $display("FAIL %s actual=event required=none (cycle %0d)", name, cyc);
    endfunction

    // Monitor
    logic       prev_stb  = 1'b0;
    logic       prev_done = 1'b0;
    logic [3:0] mon_fl;
    grant_t     mon_g;
    done_t      mon_d;

    always @(negedge clk) begin
        if (!rst) begin
            prev_stb  <= 1'b0;
            prev_done <= 1'b0;
        end else begin
            mon_fl = {bus.inst_ack, bus.inst_timeout, bus.data_ack, bus.data_timeout};
            if (prev_done) chk("gap_after_done", bus.mem_stb, 0);
            if (bus.mem_stb && !prev_stb) begin
                if (grant_q.size() == 0) begin
                    unexpected("unexpected_grant");
                end else begin
                    mon_g = grant_q.pop_front();
                    chk("grant_addr", bus.mem_addr, mon_g.addr);
                    chk("grant_we",   bus.mem_we,   mon_g.we);
                    chk("grant_dout", bus.mem_dout, mon_g.dout);
                    chk("grant_cyc",  cyc,          mon_g.cyc);
                end
            end
            if (|mon_fl) begin
                if (done_q.size() == 0) begin
                    unexpected("unexpected_done");
                end else begin
                    mon_d = done_q.pop_front();
                    chk("done_flags",     mon_fl,        mon_d.flags);
                    chk("done_inst_dout", bus.inst_dout, mon_d.rd);
                    chk("done_data_dout", bus.data_dout, mon_d.rd);
                    chk("done_cyc",       cyc,           mon_d.cyc);
                end
            end
            prev_stb  <= bus.mem_stb;
            prev_done <= |mon_fl;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One transfer: owner raises stb now, ramctrl responds lat cycles later.
    task automatic xfer(input bit is_d, input bit we, input logic [AW-1:0] a,
                        input logic [DW-1:0] wd, input logic [DW-1:0] rd,
                        input int lat, input bit to, input bit keep);
        grant_t g;
        done_t  d;
        if (is_d) begin
            bus.data_stb  = 1'b1;
            bus.data_we   = we;
            bus.data_addr = a;
            bus.data_din  = wd;
        end else begin
            bus.inst_stb  = 1'b1;
            bus.inst_addr = a;
        end
        g.we   = is_d & we;
        g.addr = a;
        g.dout = is_d ? wd : '0;
        g.cyc  = cyc + 1;
        grant_q.push_back(g);
        tick(lat);
        bus.mem_din     = rd;
        bus.mem_ack     = !to;
        bus.mem_timeout = to;
        d.flags = is_d ? {2'b00, !to, to} : {!to, to, 2'b00};
        d.rd    = rd;
        d.cyc   = cyc;
        done_q.push_back(d);
        tick(1);
        bus.mem_ack     = 1'b0;
        bus.mem_timeout = 1'b0;
        bus.mem_din     = 32'h5A5A_0000 + cyc;
        if (!keep) begin
            if (is_d) bus.data_stb = 1'b0;
            else      bus.inst_stb = 1'b0;
        end
    endtask

    initial begin
        bus.inst_stb    = 1'b0;
        bus.inst_addr   = '0;
        bus.data_stb    = 1'b0;
        bus.data_we     = 1'b0;
        bus.data_addr   = '0;
        bus.data_din    = '0;
        bus.mem_din     = 32'hA5A5_A5A5;
        bus.mem_ack     = 1'b0;
        bus.mem_timeout = 1'b0;

        // Reset state
        tick(2);
        chk("rst_mem_stb",  bus.mem_stb,  0);
        chk("rst_mem_we",   bus.mem_we,   0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_mem_dout", bus.mem_dout, 0);
        chk("rst_acks", {bus.inst_ack, bus.inst_timeout, bus.data_ack, bus.data_timeout}, 0);
        rst = 1'b1;
        tick(1);

        // Single instruction read, then data write at the top address
        xfer(1'b0, 1'b0, 27'h000_0100, '0, 32'h1234_5678, 5, 1'b0, 1'b0);
        tick(1);
        xfer(1'b1, 1'b1, 27'h7FF_FFFF, 32'hDEAD_BEEF, 32'h0BAD_F00D, 3, 1'b0, 1'b0);
        tick(2);

        // Continuous contention from reset: I,D,I,D,...
        rst = 1'b0;
        tick(2);
        rst = 1'b1;
        bus.data_stb  = 1'b1;
        bus.data_we   = 1'b0;
        bus.data_addr = 27'h100_0000;
        bus.data_din  = 32'hC0DE_0000;
        for (int k = 0; k < 8; k++) begin
            int unsigned i;
            bit keep;
            i    = k / 2;
            keep = (i < 3);
            if (k % 2 == 0) begin
                xfer(1'b0, 1'b0, 27'h000_0200 + i, '0, 32'h1111_0000 + i, 2 + (k % 3), 1'b0, keep);
                if (keep) bus.inst_addr = 27'h000_0200 + i + 1;
            end else begin
                xfer(1'b1, i[0], 27'h100_0000 + i, 32'hC0DE_0000 + i, 32'h2222_0000 + i,
                     1 + (k % 3), 1'b0, keep);
                if (keep) begin
                    bus.data_addr = 27'h100_0000 + i + 1;
                    bus.data_din  = 32'hC0DE_0000 + i + 1;
                    bus.data_we   = ~i[0];
                end
            end
        end
        tick(2);

        // Owner drops inst_stb mid-transfer; a late mem_ack must be ignored
        bus.inst_stb  = 1'b1;
        bus.inst_addr = 27'h0AB_CDEF;
        begin
            grant_t g;
            g.we = 1'b0; g.addr = 27'h0AB_CDEF; g.dout = '0; g.cyc = cyc + 1;
            grant_q.push_back(g);
        end
        tick(3);
        bus.inst_stb = 1'b0;
        @(negedge clk);
        chk("drop_mem_stb", bus.mem_stb, 0);
        tick(1);
        bus.mem_ack = 1'b1;
        bus.mem_din = 32'hFEED_FACE;
        @(negedge clk);
        chk("stray_ack", {bus.inst_ack, bus.inst_timeout, bus.data_ack, bus.data_timeout}, 0);
        tick(1);
        bus.mem_ack = 1'b0;
        tick(1);

        // Data read times out while inst waits; data wins since inst was served last
        bus.inst_stb  = 1'b1;
        bus.inst_addr = 27'h000_0300;
        xfer(1'b1, 1'b0, 27'h200_0040, '0, 32'hBAD0_BAD0, 4, 1'b1, 1'b0);
        xfer(1'b0, 1'b0, 27'h000_0300, '0, 32'h0F0F_0F0F, 2, 1'b0, 1'b0);
        tick(2);

        // Asynchronous reset during a data grant
        bus.data_stb  = 1'b1;
        bus.data_we   = 1'b1;
        bus.data_addr = 27'h300_0000;
        bus.data_din  = 32'h55AA_55AA;
        begin
            grant_t g;
            g.we = 1'b1; g.addr = 27'h300_0000; g.dout = 32'h55AA_55AA; g.cyc = cyc + 1;
            grant_q.push_back(g);
        end
        tick(2);
        chk("pre_reset_stb", bus.mem_stb, 1);
        rst         = 1'b0;
        bus.mem_ack = 1'b1;
        #2;
        chk("areset_mem_stb",  bus.mem_stb,  0);
        chk("areset_mem_we",   bus.mem_we,   0);
        chk("areset_mem_addr", bus.mem_addr, 0);
        chk("areset_mem_dout", bus.mem_dout, 0);
        chk("areset_acks", {bus.inst_ack, bus.inst_timeout, bus.data_ack, bus.data_timeout}, 0);
        bus.mem_ack  = 1'b0;
        bus.data_stb = 1'b0;
        tick(2);
        rst = 1'b1;
        bus.data_stb  = 1'b1;
        bus.data_we   = 1'b0;
        bus.data_addr = 27'h300_0001;
        bus.data_din  = '0;
        xfer(1'b0, 1'b0, 27'h000_0400, '0, 32'h7777_8888, 3, 1'b0, 1'b0);
        xfer(1'b1, 1'b0, 27'h300_0001, '0, 32'h9999_AAAA, 2, 1'b0, 1'b0);

        tick(3);
        chk("grant_q_drained", grant_q.size(), 0);
        chk("done_q_drained",  done_q.size(),  0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        errors++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
